// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   ADDR_W     : instruction address width
//   pc_state_t : fetch FSM state (IDLE = no request, FETCH = request outstanding)
package pc_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef enum logic {
    IDLE,
    FETCH
  } pc_state_t;

endpackage

// File: rtl/Inc16.sv
// 16-bit incrementer, wraps 16'hFFFF -> 16'h0000 with no carry out.
// Ports:
//   a   in  16  operand
//   out out 16  a + 1 (mod 2^16)
module Inc16
  import pc_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] out
);

  assign out = a + ADDR_W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. Issues instruction-fetch addresses over a req/ack
// handshake and advances the PC by one, or redirects it, on every accepted fetch.
//
// Optional feature macro: PC_RET_STACK_EN
//   defined   : call/ret supported through a STACK_DEPTH-entry return stack,
//               stack_err flags overflow/underflow (sticky until reset)
//   undefined : call/ret ignored, no stack storage, stack_err tied low
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   run        in   1   keep fetching back-to-back while high
//   halt_req   in   1   return to IDLE at the next accepted fetch (or stay IDLE)
//   jmp        in   1   redirect (IDLE: load pc; FETCH: applied at accept)
//   call       in   1   push return address and redirect (stack build only)
//   ret        in   1   pop return address into pc (stack build only)
//   jmp_addr   in   16  redirect target for jmp/call
//   fetch_ack  in   1   memory accepted fetch_addr this cycle
//   fetch_req  out  1   fetch request
//   fetch_addr out  16  address being fetched (equals pc)
//   pc         out  16  current program counter
//   stack_err  out  1   sticky stack over/underflow flag
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR  = 16'h0000,
  parameter int unsigned       STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              halt_req,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              fetch_ack,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_err
);

  pc_state_t         r_state;
  pc_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;

  // Single incrementer: sequential next address and the call return address.
  Inc16 u_inc16 (
    .a  (r_pc),
    .out(w_pc_inc)
  );

`ifdef PC_RET_STACK_EN
  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  // Shift-register LIFO: entry 0 is always the top of stack.
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [SpW-1:0]    r_sp;
  logic [SpW-1:0]    w_sp_nxt;
  logic              r_stack_err;
  logic              w_stack_err_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SpW'(STACK_DEPTH));
`else
  logic w_unused_stack;
  assign w_unused_stack = ^{call, ret, 32'(STACK_DEPTH)};
`endif

  // State, pc and stack control
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
`ifdef PC_RET_STACK_EN
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_stack_err_nxt = r_stack_err;
`endif
    unique case (r_state)
      IDLE: begin
        // Configuration load; a same-cycle run start fetches from jmp_addr.
        if (jmp) begin
          w_pc_nxt = jmp_addr;
        end
        if (run && !halt_req) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        // Redirect inputs are only honoured on the accept edge.
        if (fetch_ack) begin
`ifdef PC_RET_STACK_EN
          if (ret) begin
            if (w_empty) begin
              w_pc_nxt        = w_pc_inc;
              w_stack_err_nxt = 1'b1;
            end else begin
              w_pc_nxt = r_stack[0];
              w_pop    = 1'b1;
            end
          end else if (call) begin
            // Jump is taken even when the push has to be dropped.
            w_pc_nxt = jmp_addr;
            if (w_full) begin
              w_stack_err_nxt = 1'b1;
            end else begin
              w_push = 1'b1;
            end
          end else if (jmp) begin
            w_pc_nxt = jmp_addr;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
`else
          if (jmp) begin
            w_pc_nxt = jmp_addr;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
`endif
          if (halt_req || !run) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_ADDR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

`ifdef PC_RET_STACK_EN
  always_comb begin
    w_sp_nxt = r_sp;
    if (w_push) begin
      w_sp_nxt = r_sp + SpW'(1);
    end else if (w_pop) begin
      w_sp_nxt = r_sp - SpW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp        <= '0;
      r_stack_err <= 1'b0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_stack_err <= w_stack_err_nxt;
    end
  end

  // Stack storage needs no reset; r_sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[0] <= w_pc_inc;
      for (int unsigned i = 1; i < STACK_DEPTH; i++) begin
        r_stack[i] <= r_stack[i-1];
      end
    end else if (w_pop) begin
      for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) begin
        r_stack[i] <= r_stack[i+1];
      end
    end
  end

  assign stack_err = r_stack_err;
`else
  assign stack_err = 1'b0;
`endif

  assign fetch_req  = (r_state == FETCH);
  assign fetch_addr = r_pc;
  assign pc         = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected fetch addresses,
// a monitor pops and compares on every accepted fetch (fetch_req && fetch_ack).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        halt_req;
  logic        jmp;
  logic        call;
  logic        ret;
  logic [15:0] jmp_addr;
  logic        fetch_ack;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] pc;
  logic        stack_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  pc_sequencer #(
    .RESET_ADDR (16'h0000),
    .STACK_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .halt_req  (halt_req),
    .jmp       (jmp),
    .call      (call),
    .ret       (ret),
    .jmp_addr  (jmp_addr),
    .fetch_ack (fetch_ack),
    .fetch_req (fetch_req),
    .fetch_addr(fetch_addr),
    .pc        (pc),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted fetch must match the next expected address.
  always @(negedge clk) begin
    if (!reset && fetch_req && fetch_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch: got addr %h, none expected", fetch_addr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (fetch_addr !== e) begin
          errors++;
          $display("FAIL fetch_addr: got %h, expected %h", fetch_addr, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    jmp_addr = 16'h0; fetch_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a request, then accept it with the given redirect controls.
  task automatic accept_one(input logic j, input logic c, input logic r,
                            input logic [15:0] a, input bit stop);
    int guard = 0;
    while (fetch_req !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (fetch_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got fetch_req %b, expected 1", fetch_req);
    end else begin
      jmp = j; call = c; ret = r; jmp_addr = a; fetch_ack = 1'b1;
      if (stop) run = 1'b0;
      tick();
      jmp = 1'b0; call = 1'b0; ret = 1'b0; fetch_ack = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    jmp_addr = 16'h0; fetch_ack = 1'b0;
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_req", {15'b0, fetch_req}, 16'h0);
    check("rst_err", {15'b0, stack_err}, 16'h0);
    apply_reset();

    // 1: back-to-back fetches 0..3
    run = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    for (int i = 0; i < 4; i++) accept_one(1'b0, 1'b0, 1'b0, 16'h0, i == 3);
    check("t1_pc", pc, 16'h0004);
    check("t1_idle", {15'b0, fetch_req}, 16'h0);

    // 2: ack held low, address stable; ack -> next address one cycle later
    apply_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_req", {15'b0, fetch_req}, 16'h1);
      check("t2_addr", fetch_addr, 16'h0000);
      tick();
    end
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

    // 3: IDLE load with same-cycle run, wrap at 0xFFFF
    jmp = 1'b1; jmp_addr = 16'hFFFE; run = 1'b1;
    tick();
    jmp = 1'b0;
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t3_pc", pc, 16'h0001);

    // 4: jmp without ack ignored; jmp at accept of 0x0005 redirects
    apply_reset();
    run = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
    for (int i = 0; i < 5; i++) accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    jmp = 1'b1; jmp_addr = 16'h0300;
    tick();
    jmp = 1'b0;
    check("t4_noack_jmp", fetch_addr, 16'h0005);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    accept_one(1'b1, 1'b0, 1'b0, 16'h0100, 1'b0);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t4_pc", pc, 16'h0102);

    // 5: async reset mid-handshake
    run = 1'b1;
    tick();
    check("t5_req_before", {15'b0, fetch_req}, 16'h1);
    check("t5_addr_before", fetch_addr, 16'h0102);
    #1 reset = 1'b1;
    #1;
    check("t5_req_rst", {15'b0, fetch_req}, 16'h0);
    check("t5_pc_rst", pc, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0; run = 1'b0;

    // Halt wins over run in IDLE, and ends fetching at the next accept
    run = 1'b1; halt_req = 1'b1;
    tick();
    tick();
    check("halt_idle", {15'b0, fetch_req}, 16'h0);
    halt_req = 1'b0;
    tick();
    check("halt_fetch", {15'b0, fetch_req}, 16'h1);
    exp_q.push_back(16'h0000);
    halt_req = 1'b1; fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0; halt_req = 1'b0; run = 1'b0;
    check("halt_accept_req", {15'b0, fetch_req}, 16'h0);
    check("halt_accept_pc", pc, 16'h0001);

`ifdef PC_RET_STACK_EN
    // 6a: call 0x0200 at 0x0010, then ret -> 0x0011
    apply_reset();
    jmp = 1'b1; jmp_addr = 16'h0010; run = 1'b1;
    tick();
    jmp = 1'b0;
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0011);
    accept_one(1'b0, 1'b1, 1'b0, 16'h0200, 1'b0);
    accept_one(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    accept_one(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t6_pc", pc, 16'h0012);
    check("t6_err_clean", {15'b0, stack_err}, 16'h0);

    // 6b: five calls at depth 4 overflow; top still holds the fourth push
    apply_reset();
    run = 1'b1;
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h0400 + i));
    exp_q.push_back(16'h0404);
    for (int i = 0; i < 4; i++) accept_one(1'b0, 1'b1, 1'b0, 16'(16'h0400 + i), 1'b0);
    check("t6_err_full", {15'b0, stack_err}, 16'h0);
    accept_one(1'b0, 1'b1, 1'b0, 16'h0404, 1'b0);
    check("t6_err_ovf", {15'b0, stack_err}, 16'h1);
    accept_one(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    check("t6_ret_top", pc, 16'h0403);

    // 6c: ret on empty stack -> pc+1 and error
    apply_reset();
    run = 1'b1;
    exp_q.push_back(16'h0000);
    accept_one(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    check("t6_underflow_pc", pc, 16'h0001);
    check("t6_underflow_err", {15'b0, stack_err}, 16'h1);
`else
    // call/ret ignored in the stackless build (call is not a jump)
    apply_reset();
    run = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    accept_one(1'b0, 1'b1, 1'b0, 16'h0200, 1'b0);
    accept_one(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    check("nostack_pc", pc, 16'h0002);
    check("nostack_err", {15'b0, stack_err}, 16'h0);
`endif

    tick();
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
